// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and load/store.
// One transaction outstanding, round-robin tie-break, wait-cycle timeout with drop-on-flush for fetches.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o,
    input  logic        flush_i,
    input  logic        d_ce_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic [31:0] d_rdata_o,
    output logic        d_done_o,
    output logic        stallreq_o,
    output logic        err_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    typedef enum logic [1:0] {IDLE, IF_WAIT, D_WAIT} state_t;
    typedef enum logic {PRI_DATA, PRI_FETCH} pri_t;

    state_t      state_q;
    pri_t        ptr_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic        drop_q;
    logic        timeout;
    logic        d_req;
    logic        f_req;
    logic        grant_d;

    logic [31:0] if_inst_q;
    logic        if_valid_q;
    logic [31:0] d_rdata_q;
    logic        d_done_q;
    logic        err_q;
    logic        mem_ce_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    // A requester still holding ce during its own completion pulse is not a new request.
    assign d_req   = d_ce_i & ~d_done_q;
    assign f_req   = if_ce_i & ~if_valid_q;
    assign grant_d = d_req & (~f_req | (ptr_q == PRI_DATA));
    assign cnt_d   = cnt_q + 8'd1;
    assign timeout = (cnt_d == 8'hFF);

    assign stallreq_o = (d_ce_i & ~d_done_q) | (if_ce_i & ~if_valid_q & ~flush_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= PRI_DATA;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            if_inst_q   <= '0;
            if_valid_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            if_valid_q <= 1'b0;
            if_inst_q  <= '0;
            d_done_q   <= 1'b0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        mem_ce_q    <= 1'b1;
                        mem_we_q    <= d_we_i;
                        mem_addr_q  <= d_addr_i;
                        mem_wdata_q <= d_wdata_i;
                        cnt_q       <= '0;
                        state_q     <= D_WAIT;
                    end else if (f_req) begin
                        mem_ce_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr_i;
                        mem_wdata_q <= '0;
                        cnt_q       <= '0;
                        drop_q      <= 1'b0;
                        state_q     <= IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (mem_ack_i || timeout) begin
                        mem_ce_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= IDLE;
                        ptr_q    <= PRI_DATA;
                        drop_q   <= 1'b0;
                        err_q    <= ~mem_ack_i;
                        // The memory access always runs to completion; a flush only hides its result.
                        if (!(drop_q || flush_i)) begin
                            if_valid_q <= 1'b1;
                            if_inst_q  <= mem_ack_i ? mem_rdata_i : '0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (flush_i) drop_q <= 1'b1;
                    end
                end
                D_WAIT: begin
                    if (mem_ack_i || timeout) begin
                        mem_ce_q  <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= IDLE;
                        ptr_q     <= PRI_FETCH;
                        err_q     <= ~mem_ack_i;
                        d_done_q  <= 1'b1;
                        d_rdata_q <= (mem_ack_i && !mem_we_q) ? mem_rdata_i : '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_inst_o   = if_inst_q;
    assign if_valid_o  = if_valid_q;
    assign d_rdata_o   = d_rdata_q;
    assign d_done_o    = d_done_q;
    assign err_o       = err_q;
    assign mem_ce_o    = mem_ce_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle vector table plus hand-written
// sequences for arbitration, flush, timeout, reset and fairness corners.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_inst_o;
    logic        if_valid_o;
    logic        flush_i;
    logic        d_ce_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [31:0] d_rdata_o;
    logic        d_done_o;
    logic        stallreq_o;
    logic        err_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_ce_i    (if_ce_i),
        .if_addr_i  (if_addr_i),
        .if_inst_o  (if_inst_o),
        .if_valid_o (if_valid_o),
        .flush_i    (flush_i),
        .d_ce_i     (d_ce_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_rdata_o  (d_rdata_o),
        .d_done_o   (d_done_o),
        .stallreq_o (stallreq_o),
        .err_o      (err_o),
        .mem_ce_o   (mem_ce_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifce;
        logic [31:0] ifaddr;
        logic        fl;
        logic        dce;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        ack;
        logic [31:0] rdata;
        logic        e_ce;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_valid;
        logic [31:0] e_inst;
        logic        e_done;
        logic [31:0] e_rdata;
        logic        e_stall;
        logic        e_err;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        if_ce_i = 1'b0; if_addr_i = '0; flush_i = 1'b0;
        d_ce_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        zero_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic ifce, input logic [31:0] ifaddr, input logic fl,
                                input logic dce, input logic dwe, input logic [31:0] daddr,
                                input logic [31:0] dwdata, input logic ack, input logic [31:0] rdata,
                                input logic e_ce, input logic e_we, input logic [31:0] e_addr,
                                input logic [31:0] e_wdata, input logic e_valid, input logic [31:0] e_inst,
                                input logic e_done, input logic [31:0] e_rdata, input logic e_stall,
                                input logic e_err);
        vec_t v;
        v.ifce = ifce; v.ifaddr = ifaddr; v.fl = fl; v.dce = dce; v.dwe = dwe;
        v.daddr = daddr; v.dwdata = dwdata; v.ack = ack; v.rdata = rdata;
        v.e_ce = e_ce; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_done = e_done; v.e_rdata = e_rdata;
        v.e_stall = e_stall; v.e_err = e_err;
        return v;
    endfunction

    initial begin
        int cnt;
        int ng;
        logic prev_ce;
        logic [31:0] grants [4];

        // Fetch 0x100 acked two cycles after mem_ce rises, then stray ack in IDLE.
        tbl[0]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,              1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,              1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,   1, 0, 32'h100, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(1, 32'h100, 0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,         0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load 0x40 with a flush during the wait (no effect on data).
        tbl[7]  = mk(0, 0, 0, 1, 0, 32'h40, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[8]  = mk(0, 0, 1, 1, 0, 32'h40, 0, 0, 0,               1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 32'h40, 0, 1, 32'h12345678,    1, 0, 32'h40, 0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 1, 0, 32'h40, 0, 0, 0,               0, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
        // Store 0xCAFEF00D to 0x44; completion returns zero data.
        tbl[11] = mk(0, 0, 0, 1, 1, 32'h44, 32'hCAFEF00D, 0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 1, 1, 32'h44, 32'hCAFEF00D, 0, 0,    1, 1, 32'h44, 32'hCAFEF00D, 0, 0, 0, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 1, 1, 32'h44, 32'hCAFEF00D, 1, 32'hFFFFFFFF, 1, 1, 32'h44, 32'hCAFEF00D, 0, 0, 0, 0, 1, 0);
        tbl[14] = mk(0, 0, 0, 1, 1, 32'h44, 32'hCAFEF00D, 0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        #1;
        do_reset();
        rst = 1'b1;
        step();
        check("rst.mem_ce", {31'd0, mem_ce_o}, 0);
        check("rst.mem_we", {31'd0, mem_we_o}, 0);
        check("rst.mem_addr", mem_addr_o, 0);
        check("rst.mem_wdata", mem_wdata_o, 0);
        check("rst.if_valid", {31'd0, if_valid_o}, 0);
        check("rst.if_inst", if_inst_o, 0);
        check("rst.d_done", {31'd0, d_done_o}, 0);
        check("rst.d_rdata", d_rdata_o, 0);
        check("rst.err", {31'd0, err_o}, 0);
        check("rst.stall", {31'd0, stallreq_o}, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            if_ce_i = tbl[i].ifce; if_addr_i = tbl[i].ifaddr; flush_i = tbl[i].fl;
            d_ce_i = tbl[i].dce; d_we_i = tbl[i].dwe; d_addr_i = tbl[i].daddr;
            d_wdata_i = tbl[i].dwdata; mem_ack_i = tbl[i].ack; mem_rdata_i = tbl[i].rdata;
            #1;
            check($sformatf("row%0d.mem_ce", i), {31'd0, mem_ce_o}, {31'd0, tbl[i].e_ce});
            check($sformatf("row%0d.mem_we", i), {31'd0, mem_we_o}, {31'd0, tbl[i].e_we});
            check($sformatf("row%0d.if_valid", i), {31'd0, if_valid_o}, {31'd0, tbl[i].e_valid});
            check($sformatf("row%0d.d_done", i), {31'd0, d_done_o}, {31'd0, tbl[i].e_done});
            check($sformatf("row%0d.stall", i), {31'd0, stallreq_o}, {31'd0, tbl[i].e_stall});
            check($sformatf("row%0d.err", i), {31'd0, err_o}, {31'd0, tbl[i].e_err});
            if (tbl[i].e_ce) check($sformatf("row%0d.mem_addr", i), mem_addr_o, tbl[i].e_addr);
            if (tbl[i].e_we) check($sformatf("row%0d.mem_wdata", i), mem_wdata_o, tbl[i].e_wdata);
            if (tbl[i].e_valid) check($sformatf("row%0d.if_inst", i), if_inst_o, tbl[i].e_inst);
            if (tbl[i].e_done) check($sformatf("row%0d.d_rdata", i), d_rdata_o, tbl[i].e_rdata);
            @(posedge clk);
            #1;
        end

        // Simultaneous requests from reset: store wins, fetch follows the done pulse.
        do_reset();
        if_ce_i = 1'b1; if_addr_i = 32'h180;
        d_ce_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h200; d_wdata_i = 32'h55;
        step();
        check("sim.store_ce", {31'd0, mem_ce_o}, 1);
        check("sim.store_we", {31'd0, mem_we_o}, 1);
        check("sim.store_addr", mem_addr_o, 32'h200);
        check("sim.store_wdata", mem_wdata_o, 32'h55);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
        step();
        mem_ack_i = 1'b0;
        check("sim.done", {31'd0, d_done_o}, 1);
        check("sim.done_rdata", d_rdata_o, 0);
        check("sim.ce_low", {31'd0, mem_ce_o}, 0);
        d_ce_i = 1'b0;
        step();
        check("sim.fetch_ce", {31'd0, mem_ce_o}, 1);
        check("sim.fetch_we", {31'd0, mem_we_o}, 0);
        check("sim.fetch_addr", mem_addr_o, 32'h180);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0000F00D;
        step();
        mem_ack_i = 1'b0;
        check("sim.valid", {31'd0, if_valid_o}, 1);
        check("sim.inst", if_inst_o, 32'h0000F00D);
        if_ce_i = 1'b0;
        step();

        // Flush in IF_WAIT: result dropped, redirected fetch proceeds.
        do_reset();
        if_ce_i = 1'b1; if_addr_i = 32'h280;
        step();
        check("fl.ce", {31'd0, mem_ce_o}, 1);
        check("fl.addr", mem_addr_o, 32'h280);
        flush_i = 1'b1; if_addr_i = 32'h300;
        #1;
        check("fl.stall_flush", {31'd0, stallreq_o}, 0);
        step();
        flush_i = 1'b0;
        step();
        check("fl.ce_held", {31'd0, mem_ce_o}, 1);
        check("fl.addr_held", mem_addr_o, 32'h280);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        step();
        mem_ack_i = 1'b0;
        check("fl.no_valid", {31'd0, if_valid_o}, 0);
        check("fl.ce_low", {31'd0, mem_ce_o}, 0);
        step();
        check("fl.next_ce", {31'd0, mem_ce_o}, 1);
        check("fl.next_addr", mem_addr_o, 32'h300);
        mem_ack_i = 1'b1; mem_rdata_i = 32'h33333333;
        step();
        mem_ack_i = 1'b0;
        check("fl.next_valid", {31'd0, if_valid_o}, 1);
        check("fl.next_inst", if_inst_o, 32'h33333333);
        if_ce_i = 1'b0;
        step();

        // Timeout on a load with no ack.
        do_reset();
        d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
        step();
        cnt = 0;
        while (mem_ce_o && cnt < 400) begin
            cnt++;
            step();
        end
        check("tmo.wait_cycles", cnt, 255);
        check("tmo.ce_low", {31'd0, mem_ce_o}, 0);
        check("tmo.err", {31'd0, err_o}, 1);
        check("tmo.done", {31'd0, d_done_o}, 1);
        check("tmo.rdata", d_rdata_o, 0);
        d_ce_i = 1'b0;
        step();
        check("tmo.err_pulse", {31'd0, err_o}, 0);
        check("tmo.done_pulse", {31'd0, d_done_o}, 0);

        // Reset while in D_WAIT: outputs clear, late ack yields nothing.
        do_reset();
        d_ce_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h700; d_wdata_i = 32'h7777;
        step();
        step();
        check("rw.ce_before", {31'd0, mem_ce_o}, 1);
        rst = 1'b1; d_ce_i = 1'b0;
        step();
        check("rw.ce", {31'd0, mem_ce_o}, 0);
        check("rw.we", {31'd0, mem_we_o}, 0);
        check("rw.addr", mem_addr_o, 0);
        check("rw.wdata", mem_wdata_o, 0);
        check("rw.done", {31'd0, d_done_o}, 0);
        check("rw.stall", {31'd0, stallreq_o}, 0);
        rst = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h777;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rw.late_done%0d", i), {31'd0, d_done_o}, 0);
            check($sformatf("rw.late_ce%0d", i), {31'd0, mem_ce_o}, 0);
        end
        mem_ack_i = 1'b0;

        // Fetch withdrawn before being granted is never issued.
        do_reset();
        d_ce_i = 1'b1; d_addr_i = 32'h800;
        step();
        if_ce_i = 1'b1; if_addr_i = 32'h900;
        step();
        if_ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1;
        step();
        mem_ack_i = 1'b0;
        check("wd.done", {31'd0, d_done_o}, 1);
        d_ce_i = 1'b0;
        step();
        check("wd.no_ce0", {31'd0, mem_ce_o}, 0);
        step();
        check("wd.no_ce1", {31'd0, mem_ce_o}, 0);

        // Fairness: both held, memory acks immediately.
        do_reset();
        if_ce_i = 1'b1; if_addr_i = 32'h600;
        d_ce_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h500;
        prev_ce = 1'b0;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            mem_ack_i = mem_ce_o;
            mem_rdata_i = c;
            if (mem_ce_o && !prev_ce) begin
                grants[ng] = mem_addr_o;
                ng++;
            end
            prev_ce = mem_ce_o;
            step();
        end
        zero_inputs();
        check("fair.count", ng, 4);
        if (ng == 4) begin
            check("fair.g0", grants[0], 32'h500);
            check("fair.g1", grants[1], 32'h600);
            check("fair.g2", grants[2], 32'h500);
            check("fair.g3", grants[3], 32'h600);
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_ce_i  in  1  fetch request; held until if_valid_o or flush_i.
REQ-004 if_addr_i  in  32  fetch byte address.
REQ-005 if_inst_o  out  32  fetched word; valid only while if_valid_o.
REQ-006 if_valid_o  out  1  one-cycle fetch completion pulse.
REQ-007 flush_i  in  1  branch taken; discard any pending or in-flight fetch result.
REQ-008 d_ce_i  in  1  load/store request; held until d_done_o.
REQ-009 d_we_i  in  1  1 = store, 0 = load.
REQ-010 d_addr_i  in  32  data byte address.
REQ-011 d_wdata_i  in  32  store data.
REQ-012 d_rdata_o  out  32  load data; valid only while d_done_o.
REQ-013 d_done_o  out  1  one-cycle data completion pulse (load or store).
REQ-014 stallreq_o  out  1  pipeline stall request (combinational).
REQ-015 err_o  out  1  one-cycle timeout pulse.
REQ-016 mem_ce_o, mem_we_o  out  1 each  shared memory strobe and write enable (registered).
REQ-017 mem_addr_o, mem_wdata_o  out  32 each  shared memory address and write data (registered).
REQ-018 mem_rdata_i  in  32  memory read data; valid in the mem_ack_i cycle.
REQ-019 mem_ack_i  in  1  memory completion; sampled only while mem_ce_o=1.

Function
REQ-020 The block SHALL use FSM states IDLE, IF_WAIT and D_WAIT, with exactly one memory transaction outstanding.
REQ-021 In IDLE with one request present, the block SHALL grant it, latch addr/we/wdata into mem_* and enter the matching WAIT state; mem_ce_o rises the next cycle.
REQ-022 In IDLE with both requests present, the block SHALL grant the requester selected by a 1-bit priority pointer (reset = data).
REQ-023 Pointer update: after a data grant completes, pointer = fetch; after a fetch grant completes, pointer = data.
REQ-024 mem_ce_o and the mem_* outputs SHALL remain stable from grant until the ack cycle inclusive.
REQ-025 On mem_ack_i, the block SHALL deassert mem_ce_o/mem_we_o on the next edge, register mem_rdata_i and return to IDLE.
REQ-026 The completion pulse (if_valid_o or d_done_o) SHALL fire in the cycle after ack, with data held on the matching output.
REQ-027 IDLE SHALL evaluate requests in the pulse cycle with the requester's ce masked, so a new grant is possible the cycle after ack.
REQ-028 Minimum latency from a request into IDLE to its completion pulse SHALL be 3 cycles (grant, ack, pulse).
REQ-029 flush_i in IF_WAIT SHALL NOT abort the memory access; the block SHALL set a drop flag that suppresses that fetch's if_valid_o.
REQ-030 flush_i in IDLE or D_WAIT SHALL have no effect; data transactions are never cancelled.
REQ-031 A pending fetch not yet granted SHALL be dropped if if_ce_i falls.
REQ-032 stallreq_o SHALL equal (d_ce_i & ~d_done_o) | (if_ce_i & ~if_valid_o & ~flush_i).
REQ-033 An 8-bit wait counter SHALL clear on grant and increment each WAIT cycle without ack.
REQ-034 If the wait counter reaches 255, the block SHALL deassert mem_ce_o and return to IDLE.
REQ-035 On that timeout, the block SHALL pulse err_o and the requester's completion signal with data 0x00000000.
REQ-036 mem_ack_i outside a WAIT state SHALL be ignored.
REQ-037 Store completion SHALL pulse d_done_o with d_rdata_o = 0.

Reset
REQ-038 rst during a WAIT state SHALL abandon the transaction; no completion pulse SHALL follow.
REQ-039 On rst, the block SHALL set state = IDLE, pointer = data, counter = 0, drop flag = 0, and all outputs = 0.

Verification
REQ-040 Fetch only: if_ce_i=1, addr 0x100; ack 2 cycles after mem_ce_o rises with rdata 0xDEADBEEF -> if_valid_o one cycle with 0xDEADBEEF; stallreq_o high until then.
REQ-041 Simultaneous: if_ce_i and d_ce_i (store 0x55 to 0x200) from reset -> store granted first (mem_we_o=1); fetch granted on the cycle after d_done_o.
REQ-042 Flush: flush_i asserted in IF_WAIT -> memory completes the access, no if_valid_o, and a next fetch to 0x300 proceeds normally.
REQ-043 Timeout: load with no ack -> mem_ce_o drops after 255 wait cycles, err_o and d_done_o pulse, d_rdata_o=0.
REQ-044 Reset mid-transaction: rst asserted in D_WAIT -> next cycle all outputs 0, and a later ack produces no pulse.
REQ-045 Fairness: both requesters held continuously over 4 transactions -> grants alternate D, F, D, F.
